// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline hazard/stall sequencer and multiply/divide busy tracker
// Stalls F/D and bubbles E on load-use, branch-operand and HI/LO-busy hazards.
module hazard_stall_ctrl #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] IR_D,
  input  logic [WIDTH-1:0] IR_E,
  input  logic [WIDTH-1:0] IR_M,
  output logic             stall_F,
  output logic             stall_D,
  output logic             IR_E_clr,
  output logic             md_start,
  output logic             md_busy
);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09, OP_ORI = 6'h0d, OP_LUI = 6'h0f;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] FN_JR = 6'h08, FN_MFHI = 6'h10, FN_MTHI = 6'h11, FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MTLO = 6'h13, FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV = 6'h1a;
  localparam logic [5:0] FN_DIVU = 6'h1b, FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_SLT = 6'h2a;
  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       start_raw;
  logic       haz_lu, haz_br_e, haz_br_m, haz_md, stall;

  // Only fields below bit 32 are decoded; wider words carry nothing relevant here.
  logic unused_ir;
  assign unused_ir = ^{IR_D, IR_E, IR_M};

  function automatic logic is_md(input logic [WIDTH-1:0] ir);
    return ir[31:26] == OP_RTYPE && ir[5:0] inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
  endfunction

  function automatic logic is_hilo(input logic [WIDTH-1:0] ir);
    return is_md(ir) || (ir[31:26] == OP_RTYPE &&
           ir[5:0] inside {FN_MFHI, FN_MFLO, FN_MTHI, FN_MTLO});
  endfunction

  function automatic logic is_branch(input logic [WIDTH-1:0] ir);
    return ir[31:26] inside {OP_BEQ, OP_BNE} || (ir[31:26] == OP_RTYPE && ir[5:0] == FN_JR);
  endfunction

  function automatic logic [4:0] dest_reg(input logic [WIDTH-1:0] ir);
    logic [4:0] d;
    d = 5'd0;
    if (ir[31:26] == OP_RTYPE) begin
      if (ir[5:0] inside {FN_ADDU, FN_SUBU, FN_SLT, FN_MFHI, FN_MFLO}) d = ir[15:11];
    end else if (ir[31:26] inside {OP_ORI, OP_LUI, OP_ADDIU, OP_LW}) begin
      d = ir[20:16];
    end else if (ir[31:26] == OP_JAL) begin
      d = 5'd31;
    end
    return d;
  endfunction

  function automatic logic uses_rs(input logic [WIDTH-1:0] ir);
    if (ir[31:26] == OP_RTYPE)
      return ir[5:0] inside {FN_ADDU, FN_SUBU, FN_SLT, FN_JR, FN_MULT, FN_MULTU,
                             FN_DIV, FN_DIVU, FN_MTHI, FN_MTLO};
    return ir[31:26] inside {OP_ORI, OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_BNE};
  endfunction

  function automatic logic uses_rt(input logic [WIDTH-1:0] ir);
    if (ir[31:26] == OP_RTYPE)
      return ir[5:0] inside {FN_ADDU, FN_SUBU, FN_SLT, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
    return ir[31:26] inside {OP_SW, OP_BEQ, OP_BNE};
  endfunction

  // A write to $0 never creates a dependency, which also keeps nop bubbles hazard-free.
  function automatic logic depends(input logic [WIDTH-1:0] ir, input logic [4:0] r);
    return r != 5'd0 && ((uses_rs(ir) && ir[25:21] == r) || (uses_rt(ir) && ir[20:16] == r));
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // MD ops arriving in E while BUSY are ignored rather than restarting the count.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    start_raw = 1'b0;
    case (state)
      IDLE: begin
        if (is_md(IR_E)) begin
          start_raw = 1'b1;
          cnt_nx    = IR_E[1] ? DIV_CNT : MULT_CNT;
          state_nx  = BUSY;
        end
      end
      BUSY: begin
        if (cnt == 4'd1) begin
          cnt_nx   = 4'd0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  always_comb begin
    haz_lu   = IR_E[31:26] == OP_LW && depends(IR_D, dest_reg(IR_E));
    haz_br_e = is_branch(IR_D) && depends(IR_D, dest_reg(IR_E));
    haz_br_m = is_branch(IR_D) && IR_M[31:26] == OP_LW && depends(IR_D, dest_reg(IR_M));
    haz_md   = is_hilo(IR_D) && (state == BUSY || start_raw);
    stall    = haz_lu || haz_br_e || haz_br_m || haz_md;
  end

  assign stall_F  = stall && rst_n;
  assign stall_D  = stall && rst_n;
  assign IR_E_clr = stall && rst_n;
  assign md_start = start_raw && rst_n;
  assign md_busy  = (state == BUSY) && rst_n;

endmodule
